// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - registered valid/ready pipeline stage with stall counter; PIPE_STAGE_SKID_EN adds a skid entry
module pipe_stage_reg #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Stall counter saturates and survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
    assign in_ready = !skid_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            // in_ready is low while the skid is full, so draining never collides with a new input.
            if (out_ready) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end
        end else if (out_valid && !out_ready) begin
            if (in_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= in_data;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg (queue scoreboard, both PIPE_STAGE_SKID_EN builds)
module tb_pipe_stage_reg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_stage_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: accepted payloads queued in order, head is what out_data must show.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] exp_stall;
    logic             m_rdy;

    function automatic logic model_ready();
`ifdef PIPE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_ready;
`endif
    endfunction

    always @(posedge clk) begin
        m_rdy = model_ready();
        if (!rst) begin
            q.delete();
            exp_data  = '0;
            exp_stall = '0;
        end else begin
            if (q.size() != 0 && !out_ready && exp_stall != '1) exp_stall = exp_stall + CNT_W'(1);
            if (flush) begin
                q.delete();
            end else begin
                if (q.size() != 0 && out_ready) void'(q.pop_front());
                if (in_valid && m_rdy) q.push_back(in_data);
                if (q.size() != 0) exp_data = q[0];
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; flush = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_stays_empty got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) begin in_valid = 1'b1; in_data = WIDTH'(i); end
            else in_valid = 1'b0;
            @(negedge clk);
            if (i <= 8) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(i))
                    $display("FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, WIDTH'(i));
                else n_pass++;
            end else begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_end got v=%b want 0", out_valid); else n_pass++;
            end
        end
    endtask

    task automatic test_stall();
        int extra = 0;
        do_reset();
        in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'hB6B6_0002;
        repeat (5) begin
            if (in_ready) extra++;
            @(negedge clk);
        end
        n_checks++; if (out_data !== 32'hA5A5_0001) $display("FAIL stall_out_data got %h want a5a50001", out_data); else n_pass++;
        n_checks++; if (stall_cnt !== CNT_W'(5)) $display("FAIL stall_cnt got %0d want 5", stall_cnt); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (extra != DEPTH - 1) $display("FAIL stall_extra_accepts got %0d want %0d", extra, DEPTH - 1); else n_pass++;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (out_valid !== (q.size() != 0) || (out_valid && out_data !== exp_data))
                $display("FAIL stall_drain got v=%b d=%h want v=%b d=%h", out_valid, out_data, q.size() != 0, exp_data);
            else n_pass++;
        end
        n_checks++; if (stall_cnt !== exp_stall) $display("FAIL stall_cnt_hold got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 32'h0000_00AA; out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'h0000_00BB; flush = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid got %b want 0", out_valid); else n_pass++;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0 || out_data !== 32'h0000_00AA)
                $display("FAIL flush_no_b got v=%b d=%h want v=0 d=000000aa", out_valid, out_data);
            else n_pass++;
        end
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        in_valid = 1'b1; in_data = 32'h0000_0C0C; out_ready = 1'b0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        n_checks++; if (stall_cnt !== CNT_W'(3) || out_valid !== 1'b1)
            $display("FAIL rms_pre got cnt=%0d v=%b want cnt=3 v=1", stall_cnt, out_valid);
        else n_pass++;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rms_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL rms_out_data got %h want 0", out_data); else n_pass++;
        n_checks++; if (stall_cnt !== '0) $display("FAIL rms_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rms_in_ready got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_data = 32'h0000_0D0D; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 14 || i >= 15) begin
                n_checks++; if (stall_cnt !== CNT_W'((i > 15) ? 15 : i))
                    $display("FAIL sat_cycle%0d got %0d want %0d", i, stall_cnt, (i > 15) ? 15 : i);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== (q.size() != 0) || (out_valid && out_data !== exp_data))
                $display("FAIL rand_out c=%0d got v=%b d=%h want v=%b d=%h", c, out_valid, out_data, q.size() != 0, exp_data);
            else n_pass++;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = $urandom();
            #1;
            n_checks++; if (in_ready !== model_ready())
                $display("FAIL rand_in_ready c=%0d got %b want %b", c, in_ready, model_ready());
            else n_pass++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || q.size() != 0)
            $display("FAIL rand_drain got v=%b left=%0d want v=0 left=0", out_valid, q.size());
        else n_pass++;
        n_checks++; if (stall_cnt !== exp_stall) $display("FAIL rand_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
